// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus writer: FSM states, init
// command bytes, default timing and the clear/home wait classifier.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      WAIT,
      PWR_WAIT
   } lcd_state_t;

   localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

   localparam int T_SETUP_DEF = 4;
   localparam int T_EN_DEF    = 16;
   localparam int T_HOLD_DEF  = 4;
   localparam int T_EXEC_DEF  = 2500;
   localparam int T_CLEAR_DEF = 82000;
   localparam int T_PWR_DEF   = 750000;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
   endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; done flags the terminal count of zero.
module lcd_delay_counter #(
   parameter int W = 8
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// HD44780 write-only bus timing engine: one byte per valid/ready handshake.
// Optional power-on init sequence when LCD_INIT_SEQ_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a request (oReady=1)
// SETUP    | RS/DATA settling before E rises
// PULSE    | LCD_E high
// HOLD     | RS/DATA held after E falls
// WAIT     | controller execution time (short, or long for clear/home)
// PWR_WAIT | power-on delay before the built-in init bytes
module lcd_bus_writer
   import lcd_pkg::*;
#(
   parameter int T_SETUP_CYC = T_SETUP_DEF,
   parameter int T_EN_CYC    = T_EN_DEF,
   parameter int T_HOLD_CYC  = T_HOLD_DEF,
   parameter int T_EXEC_CYC  = T_EXEC_DEF,
   parameter int T_CLEAR_CYC = T_CLEAR_DEF,
   parameter int T_PWR_CYC   = T_PWR_DEF
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iValid,
   input  logic       iRS,
   input  logic [7:0] iData,
   output logic       oReady,
   output logic       oInitDone,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_E
);

   localparam int T_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_EXEC_CYC)),
                               max2(T_CLEAR_CYC, T_PWR_CYC));
   localparam int CW = $clog2(T_MAX) + 1;

   // Counter holds (cycles - 1) so a state ends on the cycle it reads zero.
   localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
   localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
   localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC_CYC - 1);
   localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR_CYC - 1);

`ifdef LCD_INIT_SEQ_EN
   // PWR_WAIT spends its first cycle loading, so the load is two short.
   localparam logic [CW-1:0] LD_PWR = CW'((T_PWR_CYC > 1) ? (T_PWR_CYC - 2) : 0);
   localparam lcd_state_t RST_STATE = PWR_WAIT;
   localparam logic [7:0] INIT_ROM [4] = '{CMD_FUNC_8B2L, CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY_INC};
`else
   localparam lcd_state_t RST_STATE = IDLE;
`endif

   lcd_state_t    state, state_nxt;
   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          cnt_done;
   logic          latch_en;
   logic          latch_rs;
   logic [7:0]    latch_data;

`ifdef LCD_INIT_SEQ_EN
   logic [1:0]    init_idx;
   logic          init_done_q;
   logic          pwr_started;
   logic          init_adv;
`endif

   lcd_delay_counter #(.W(CW)) u_delay (
      .clk_sys  (iCLK),
      .rst_b    (iRST_N),
      .load     (cnt_load),
      .load_val (cnt_val),
      .done     (cnt_done)
   );

   always_comb begin
      state_nxt  = state;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      latch_en   = 1'b0;
      latch_rs   = 1'b0;
      latch_data = 8'h00;
`ifdef LCD_INIT_SEQ_EN
      init_adv   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (iValid) begin
               state_nxt  = SETUP;
               cnt_load   = 1'b1;
               cnt_val    = LD_SETUP;
               latch_en   = 1'b1;
               latch_rs   = iRS;
               latch_data = iData;
            end
         end
         SETUP: begin
            if (cnt_done) begin
               state_nxt = PULSE;
               cnt_load  = 1'b1;
               cnt_val   = LD_EN;
            end
         end
         PULSE: begin
            if (cnt_done) begin
               state_nxt = HOLD;
               cnt_load  = 1'b1;
               cnt_val   = LD_HOLD;
            end
         end
         HOLD: begin
            if (cnt_done) begin
               state_nxt = WAIT;
               cnt_load  = 1'b1;
               cnt_val   = is_long_cmd(LCD_RS, LCD_DATA) ? LD_CLEAR : LD_EXEC;
            end
         end
         WAIT: begin
            if (cnt_done) begin
               state_nxt = IDLE;
`ifdef LCD_INIT_SEQ_EN
               if (!init_done_q) begin
                  init_adv = 1'b1;
                  if (init_idx != 2'd3) begin
                     state_nxt  = SETUP;
                     cnt_load   = 1'b1;
                     cnt_val    = LD_SETUP;
                     latch_en   = 1'b1;
                     latch_data = INIT_ROM[init_idx + 2'd1];
                  end
               end
`endif
            end
         end
         PWR_WAIT: begin
`ifdef LCD_INIT_SEQ_EN
            if (!pwr_started && (T_PWR_CYC > 1)) begin
               cnt_load = 1'b1;
               cnt_val  = LD_PWR;
            end else if (cnt_done) begin
               state_nxt  = SETUP;
               cnt_load   = 1'b1;
               cnt_val    = LD_SETUP;
               latch_en   = 1'b1;
               latch_data = INIT_ROM[0];
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state    <= RST_STATE;
         LCD_E    <= 1'b0;
         LCD_RS   <= 1'b0;
         LCD_DATA <= 8'h00;
      end else begin
         state <= state_nxt;
         LCD_E <= (state_nxt == PULSE);
         if (latch_en) begin
            LCD_RS   <= latch_rs;
            LCD_DATA <= latch_data;
         end
      end
   end

`ifdef LCD_INIT_SEQ_EN
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         init_idx    <= 2'd0;
         init_done_q <= 1'b0;
         pwr_started <= 1'b0;
      end else begin
         if (state == PWR_WAIT) begin
            pwr_started <= 1'b1;
         end
         if (init_adv) begin
            if (init_idx == 2'd3) begin
               init_done_q <= 1'b1;
            end else begin
               init_idx <= init_idx + 2'd1;
            end
         end
      end
   end

   assign oInitDone = init_done_q;
`else
   assign oInitDone = 1'b1;
`endif

   assign oReady = (state == IDLE);
   assign LCD_RW = 1'b0;

endmodule
